// File: rtl/stk_eng_cmd.sv
`default_nettype none
// ============================================================================
// Module      : stk_eng_cmd (with package stk_pkg)
// Description : Per-engine command issuer for the stack pipeline. Buffers
//               PUSH/POP requests in a small FIFO, holds each command on the
//               pipe lane until acked, and tracks acked-but-unresponded
//               commands against a credit limit.
//               Optional feature macro: STK_ENG_CMD_TMO_EN (ack watchdog).
// Revision    : 1.0 - initial release
// ============================================================================

package stk_pkg;
    typedef enum logic [1:0] {
        NOP  = 2'd0,
        PUSH = 2'd1,
        POP  = 2'd2
    } opcode_t;
endpackage

module stk_eng_cmd #(
    parameter int FIFO_N     = 4,
    parameter int INFLIGHT_N = 8,
    parameter int TMO_CYC    = 1023
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_vld,
    input  stk_pkg::opcode_t in_opcode,
    input  logic [127:0]     in_dat,
    output logic             in_rdy,
    output stk_pkg::opcode_t cmd_opcode,
    output logic [127:0]     cmd_dat,
    input  logic             cmd_ack,
    input  logic             rsp_vld,
    output logic             rsp_done,
    output logic [7:0]       inflight,
    output logic             idle,
    output logic [1:0]       err_r
);
    import stk_pkg::*;

    localparam int       c_AW  = $clog2(FIFO_N);
    localparam bit [7:0] c_INF = 8'(INFLIGHT_N);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_STALL = 2'd2
    } state_t;

    state_t          r_cs;
    opcode_t         r_cmd_op;
    logic [127:0]    r_cmd_dat;
    opcode_t         r_mem_op  [FIFO_N];
    logic [127:0]    r_mem_dat [FIFO_N];
    logic [c_AW:0]   r_wp;
    logic [c_AW:0]   r_rp;
    logic            r_in_rdy;
    logic [7:0]      r_inflight;
    logic            r_rsp_done;
    logic            r_err_rsp;
    logic            w_err_tmo;

    logic            w_empty;
    logic            w_push;
    logic            w_ack;
    logic            w_rsp_ok;
    logic            w_load;
    logic [7:0]      w_inf_nxt;
    logic [c_AW:0]   w_wp_nxt;
    logic [c_AW:0]   w_rp_nxt;
    logic            w_full_nxt;

    assign w_empty   = (r_wp == r_rp);
    assign w_push    = in_vld && r_in_rdy && (in_opcode != NOP);
    assign w_ack     = (r_cs == S_ISSUE) && cmd_ack;
    // A response with nothing in flight is an error, not a credit return.
    assign w_rsp_ok  = rsp_vld && (r_inflight != 8'd0);
    assign w_inf_nxt = r_inflight + {7'd0, w_ack} - {7'd0, w_rsp_ok};

    // Head loads from IDLE/STALL on current credit; from ISSUE only on ack,
    // judged against the credit count after this cycle's update.
    always_comb begin
        w_load = 1'b0;
        case (r_cs)
            S_IDLE, S_STALL: w_load = !w_empty && (r_inflight < c_INF);
            S_ISSUE:         w_load = w_ack && !w_empty && (w_inf_nxt < c_INF);
            default:         w_load = 1'b0;
        endcase
    end

    assign w_wp_nxt   = r_wp + (c_AW+1)'(w_push);
    assign w_rp_nxt   = r_rp + (c_AW+1)'(w_load);
    assign w_full_nxt = (w_wp_nxt[c_AW] != w_rp_nxt[c_AW]) &&
                        (w_wp_nxt[c_AW-1:0] == w_rp_nxt[c_AW-1:0]);

    // FIFO storage; contents need no reset since the pointers define validity.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_op[r_wp[c_AW-1:0]]  <= in_opcode;
            r_mem_dat[r_wp[c_AW-1:0]] <= in_dat;
        end
    end

    // FIFO pointers and registered ready derived from next-state fullness.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wp     <= '0;
            r_rp     <= '0;
            r_in_rdy <= 1'b1;
        end else begin
            r_wp     <= w_wp_nxt;
            r_rp     <= w_rp_nxt;
            r_in_rdy <= !w_full_nxt;
        end
    end

    // Issue FSM with registered command lane.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cs      <= S_IDLE;
            r_cmd_op  <= NOP;
            r_cmd_dat <= '0;
        end else begin
            if (w_load) begin
                r_cs      <= S_ISSUE;
                r_cmd_op  <= r_mem_op[r_rp[c_AW-1:0]];
                r_cmd_dat <= r_mem_dat[r_rp[c_AW-1:0]];
            end else begin
                case (r_cs)
                    S_IDLE, S_STALL: begin
                        r_cs <= w_empty ? S_IDLE : S_STALL;
                    end
                    S_ISSUE: begin
                        if (w_ack) begin
                            r_cs      <= w_empty ? S_IDLE : S_STALL;
                            r_cmd_op  <= NOP;
                            r_cmd_dat <= '0;
                        end
                    end
                    default: begin
                        r_cs      <= S_IDLE;
                        r_cmd_op  <= NOP;
                        r_cmd_dat <= '0;
                    end
                endcase
            end
        end
    end

    // Credit tracking, response echo and sticky response error.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_inflight <= 8'd0;
            r_rsp_done <= 1'b0;
            r_err_rsp  <= 1'b0;
        end else begin
            r_inflight <= w_inf_nxt;
            r_rsp_done <= w_rsp_ok;
            if (rsp_vld && (r_inflight == 8'd0)) begin
                r_err_rsp <= 1'b1;
            end
        end
    end

`ifdef STK_ENG_CMD_TMO_EN
    localparam logic [9:0] c_TMO = 10'(TMO_CYC);
    logic [9:0] r_tmo;
    logic       r_err_tmo;

    // Watchdog on cycles spent holding a command without ack.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tmo     <= 10'd0;
            r_err_tmo <= 1'b0;
        end else if ((r_cs == S_ISSUE) && !cmd_ack) begin
            if (r_tmo != c_TMO) begin
                r_tmo <= r_tmo + 10'd1;
            end
            if (r_tmo == (c_TMO - 10'd1)) begin
                r_err_tmo <= 1'b1;
            end
        end else begin
            r_tmo <= 10'd0;
        end
    end

    assign w_err_tmo = r_err_tmo;
`else
    assign w_err_tmo = 1'b0;
`endif

    assign in_rdy     = r_in_rdy;
    assign cmd_opcode = r_cmd_op;
    assign cmd_dat    = r_cmd_dat;
    assign rsp_done   = r_rsp_done;
    assign inflight   = r_inflight;
    assign idle       = w_empty && (r_cs != S_ISSUE) && (r_inflight == 8'd0);
    assign err_r      = {w_err_tmo, r_err_rsp};

endmodule
`default_nettype wire

// File: tb/tb_stk_eng_cmd.sv
`default_nettype none
// ============================================================================
// Module      : tb_stk_eng_cmd
// Description : Self-checking bench for stk_eng_cmd. A queue-based model of
//               the command issuer predicts every output each cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_stk_eng_cmd;
    import stk_pkg::*;

    localparam int c_FIFO_N = 4;
    localparam int c_INF_N  = 4;
    localparam int c_TMO    = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_vld;
    opcode_t      in_opcode;
    logic [127:0] in_dat;
    logic         in_rdy;
    opcode_t      cmd_opcode;
    logic [127:0] cmd_dat;
    logic         cmd_ack;
    logic         rsp_vld;
    logic         rsp_done;
    logic [7:0]   inflight;
    logic         idle;
    logic [1:0]   err_r;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    opcode_t      q_op[$];
    logic [127:0] q_dat[$];
    bit           m_held;
    opcode_t      m_op;
    logic [127:0] m_dat;
    int           m_inf;
    bit           m_rdy;
    bit           m_done;
    bit [1:0]     m_err;
    int           m_tmo;

    stk_eng_cmd #(
        .FIFO_N     (c_FIFO_N),
        .INFLIGHT_N (c_INF_N),
        .TMO_CYC    (c_TMO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_vld     (in_vld),
        .in_opcode  (in_opcode),
        .in_dat     (in_dat),
        .in_rdy     (in_rdy),
        .cmd_opcode (cmd_opcode),
        .cmd_dat    (cmd_dat),
        .cmd_ack    (cmd_ack),
        .rsp_vld    (rsp_vld),
        .rsp_done   (rsp_done),
        .inflight   (inflight),
        .idle       (idle),
        .err_r      (err_r)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("in_rdy",     128'(in_rdy),     128'(m_rdy));
        chk("cmd_opcode", 128'(cmd_opcode), m_held ? 128'(m_op) : 128'(NOP));
        chk("cmd_dat",    cmd_dat,          m_held ? m_dat : 128'd0);
        chk("inflight",   128'(inflight),   128'(m_inf));
        chk("rsp_done",   128'(rsp_done),   128'(m_done));
        chk("idle",       128'(idle),       128'((q_op.size() == 0) && !m_held && (m_inf == 0)));
        chk("err_r",      128'(err_r),      128'(m_err));
    endtask

    task automatic model_reset();
        q_op.delete();
        q_dat.delete();
        m_held = 0; m_op = NOP; m_dat = '0; m_inf = 0;
        m_rdy = 1; m_done = 0; m_err = 2'b00; m_tmo = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1; in_vld = 1'b0; in_opcode = NOP; in_dat = '0;
        cmd_ack = 1'b0; rsp_vld = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        check_all();
    endtask

    // One clock: drive inputs, advance the model, then compare after the edge.
    task automatic step(input bit vld, input opcode_t op, input logic [127:0] dat,
                        input bit ack, input bit rsp);
        bit acked, rok, can_push;
        int inf_n;
        in_vld = vld; in_opcode = op; in_dat = dat; cmd_ack = ack; rsp_vld = rsp;
        can_push = m_rdy && vld && (op != NOP);
        acked = m_held && ack;
        rok   = rsp && (m_inf > 0);
        if (rsp && (m_inf == 0)) m_err[0] = 1'b1;
        inf_n = m_inf + int'(acked) - int'(rok);
`ifdef STK_ENG_CMD_TMO_EN
        if (m_held && !ack) begin
            if (m_tmo < c_TMO) m_tmo++;
            if (m_tmo == c_TMO) m_err[1] = 1'b1;
        end else begin
            m_tmo = 0;
        end
`endif
        if (m_held) begin
            if (acked) begin
                if ((q_op.size() > 0) && (inf_n < c_INF_N)) begin
                    m_op = q_op.pop_front(); m_dat = q_dat.pop_front();
                end else begin
                    m_held = 0;
                end
            end
        end else if ((q_op.size() > 0) && (m_inf < c_INF_N)) begin
            m_held = 1; m_op = q_op.pop_front(); m_dat = q_dat.pop_front();
        end
        if (can_push) begin
            q_op.push_back(op); q_dat.push_back(dat);
        end
        m_inf  = inf_n;
        m_done = rok;
        m_rdy  = (q_op.size() != c_FIFO_N);
        @(posedge clk); #1;
        check_all();
    endtask

    initial begin
        model_reset();
        do_reset();

        // Single PUSH with ack tied high: one-cycle command pulse
        step(1, PUSH, 128'hA5, 1, 0);
        step(0, NOP,  128'h0,  1, 0);
        chk("push_a5_op",  128'(cmd_opcode), 128'(PUSH));
        chk("push_a5_dat", cmd_dat,          128'hA5);
        step(0, NOP, 128'h0, 1, 0);
        chk("push_a5_inf", 128'(inflight), 128'd1);
        step(0, NOP, 128'h0, 1, 0);
        step(0, NOP, 128'h0, 0, 1);

        // Fill FIFO and held register with ack low, then ack continuously
        for (int i = 0; i < 7; i++) step(1, PUSH, 128'(32'h100 + i), 0, 0);
        for (int i = 0; i < 7; i++) step(0, NOP, 128'h0, 1, 0);
        chk("fill_inf_cap", 128'(inflight), 128'(c_INF_N));
        // Credit stalled: return responses and let the rest drain
        for (int i = 0; i < 10; i++) step(0, NOP, 128'h0, 1, (m_inf > 0));

        // Credit limit with POPs, then a single response releases one more
        do_reset();
        for (int i = 0; i < 6; i++) step(1, POP, 128'h0, 1, 0);
        for (int i = 0; i < 3; i++) step(0, NOP, 128'h0, 1, 0);
        chk("stall_nop", 128'(cmd_opcode), 128'(NOP));
        step(0, NOP, 128'h0, 1, 1);
        for (int i = 0; i < 3; i++) step(0, NOP, 128'h0, 1, 0);

        // Same-cycle ack and response at inflight 3 keeps the count
        do_reset();
        for (int i = 0; i < 4; i++) step(1, PUSH, 128'(i), (i < 3), 0);
        step(0, NOP, 128'h0, 1, 0);
        step(0, NOP, 128'h0, 1, 0);
        step(0, NOP, 128'h0, 0, 0);
        chk("pre_both_inf", 128'(inflight), 128'd3);
        step(0, NOP, 128'h0, 1, 1);
        chk("both_inf", 128'(inflight), 128'd3);
        for (int i = 0; i < 4; i++) step(0, NOP, 128'h0, 0, 1);
        step(0, NOP, 128'h0, 0, 1);
        chk("err_rsp0", 128'(err_r), 128'(m_err));

        // Reset while a command is held with more queued
        do_reset();
        for (int i = 0; i < 4; i++) step(1, PUSH, 128'(i + 7), 0, 0);
        do_reset();
        chk("rst_idle", 128'(idle), 128'd1);

        // Ack held low long enough to trip the watchdog (when built in)
        step(1, POP, 128'h0, 0, 0);
        for (int i = 0; i < 22; i++) step(0, NOP, 128'h0, 0, 0);
        chk("tmo_held", 128'(cmd_opcode), 128'(POP));
        step(0, NOP, 128'h0, 1, 0);

        // Randomized traffic against the model
        do_reset();
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 3) != 0), opcode_t'($urandom_range(0, 2)),
                 {$urandom, $urandom, $urandom, $urandom},
                 ($urandom_range(0, 2) != 0), ($urandom_range(0, 3) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
